// File: rtl/residual_binarizer_pkg.sv
// Shared definitions for the residual binarizer: FSM encodings and the
// signed residual width helper also used by PopCount-side checkers.
package residual_binarizer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Width that holds |r| <= 2^(A-1) + L*(2^A-1) without overflow.
  function automatic int res_width(input int levels, input int act_w);
    return act_w + $clog2(levels + 1) + 1;
  endfunction

endpackage

// File: rtl/residual_binarizer_lane.sv
// One SIMD lane: residual register plus the sign/update step.
module residual_binarizer_lane
  import residual_binarizer_pkg::*;
#(
  parameter int ACT_WIDTH = 8,
  parameter int RES_WIDTH = res_width(2, 8)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [ACT_WIDTH-1:0] act_in,
  input  logic [ACT_WIDTH-1:0] gamma_sel,
  output logic                 bit_out,
  output logic [RES_WIDTH-1:0] res
);

  logic [RES_WIDTH-1:0] res_q;
  logic [RES_WIDTH-1:0] res_d;
  logic [RES_WIDTH-1:0] gamma_ext;
  logic [RES_WIDTH-1:0] act_ext;

  assign gamma_ext = {{(RES_WIDTH-ACT_WIDTH){1'b0}}, gamma_sel};
  assign act_ext   = {{(RES_WIDTH-ACT_WIDTH){act_in[ACT_WIDTH-1]}}, act_in};

  // Non-negative residual (including zero) encodes as +gamma.
  assign bit_out = ~res_q[RES_WIDTH-1];
  assign res     = res_q;

  // Next residual: load sign-extended activation, or step toward zero.
  always_comb begin
    res_d = res_q;
    if (load) begin
      res_d = act_ext;
    end else if (step) begin
      res_d = bit_out ? (res_q - gamma_ext) : (res_q + gamma_ext);
    end
  end

  // Residual register.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

endmodule

// File: rtl/residual_binarizer.sv
// Residual binarization encoder: one level per clock, SIMD_WIDTH lanes in
// parallel, producing WEIGHT_LEVELS bit planes and the final residuals.
module residual_binarizer
  import residual_binarizer_pkg::*;
#(
  parameter int  WEIGHT_LEVELS = 2,
  parameter int  SIMD_WIDTH    = 4,
  parameter int  ACT_WIDTH     = 8,
  localparam int RW            = res_width(WEIGHT_LEVELS, ACT_WIDTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [ACT_WIDTH*SIMD_WIDTH-1:0]   act,
  input  logic [ACT_WIDTH*WEIGHT_LEVELS-1:0] gamma,
  output logic [WEIGHT_LEVELS*SIMD_WIDTH-1:0] out,
  output logic [RW*SIMD_WIDTH-1:0]          res_out,
  output logic                              busy,
  output logic                              done
);

  localparam int L  = WEIGHT_LEVELS;
  localparam int S  = SIMD_WIDTH;
  localparam int A  = ACT_WIDTH;
  localparam int LW = $clog2(L) + 1;

  logic [1:0]     state_q, state_d;
  logic [LW-1:0]  lvl_q, lvl_d;
  logic [A*L-1:0] gamma_q, gamma_d;
  logic [L*S-1:0] out_q, out_d;

  logic           load;
  logic           step;
  logic [A-1:0]   gamma_sel;
  logic [S-1:0]   lane_bit;

  assign load = (state_q == ST_IDLE) && start;
  assign step = (state_q == ST_RUN);

  // Select the captured scale for the level being processed this cycle.
  always_comb begin
    gamma_sel = '0;
    for (int l = 0; l < L; l++) begin
      if (lvl_q == LW'(l)) begin
        gamma_sel = gamma_q[l*A +: A];
      end
    end
  end

  // FSM, level counter, gamma capture and bit-plane update.
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    gamma_d = gamma_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          lvl_d   = '0;
          gamma_d = gamma;
          out_d   = '0;
        end
      end
      ST_RUN: begin
        // Only the current level's plane is written; other planes hold.
        for (int l = 0; l < L; l++) begin
          for (int s = 0; s < S; s++) begin
            if (lvl_q == LW'(l)) begin
              out_d[l*S+s] = lane_bit[s];
            end
          end
        end
        if (lvl_q == LW'(L-1)) begin
          state_d = ST_DONE;
        end else begin
          lvl_d = lvl_q + LW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and plane registers; reset discards any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lvl_q   <= '0;
      gamma_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      gamma_q <= gamma_d;
      out_q   <= out_d;
    end
  end

  for (genvar gi = 0; gi < S; gi++) begin : g_lane
    residual_binarizer_lane #(
      .ACT_WIDTH (A),
      .RES_WIDTH (RW)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .step      (step),
      .act_in    (act[gi*A +: A]),
      .gamma_sel (gamma_sel),
      .bit_out   (lane_bit[gi]),
      .res       (res_out[gi*RW +: RW])
    );
  end

  assign out  = out_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_residual_binarizer.sv
// Scoreboard bench for residual_binarizer: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_residual_binarizer;

  localparam int L  = 2;
  localparam int S  = 4;
  localparam int A  = 8;
  localparam int RW = A + $clog2(L + 1) + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [A*S-1:0] act = '0;
  logic [A*L-1:0] gamma = '0;
  logic [L*S-1:0] out;
  logic [RW*S-1:0] res_out;
  logic           busy;
  logic           done;

  residual_binarizer #(
    .WEIGHT_LEVELS (L),
    .SIMD_WIDTH    (S),
    .ACT_WIDTH     (A)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .act     (act),
    .gamma   (gamma),
    .out     (out),
    .res_out (res_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int pcyc = 0;
  always @(posedge clk) pcyc++;

  typedef struct {
    logic [L*S-1:0]  out;
    logic [RW*S-1:0] res;
    logic [A*S-1:0]  act;
    logic [A*L-1:0]  gam;
    int              due;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_issued = 0;
  int n_done   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, req, $time);
    end
  endtask

  // Reference: each level picks the sign of the running residual (zero -> +)
  // and moves the residual by that level's scale, in plain integer arithmetic.
  function automatic void model(input logic [A*S-1:0] a, input logic [A*L-1:0] g,
                                output logic [L*S-1:0] o, output logic [RW*S-1:0] r);
    o = '0;
    r = '0;
    for (int s = 0; s < S; s++) begin
      int v;
      v = int'($signed(a[s*A +: A]));
      for (int l = 0; l < L; l++) begin
        int gv;
        gv = int'({24'd0, g[l*A +: A]});
        if (v >= 0) begin
          o[l*S+s] = 1'b1;
          v = v - gv;
        end else begin
          v = v + gv;
        end
      end
      r[s*RW +: RW] = RW'(v);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  exp_t e_mon;
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        int bad;
        e_mon = sb.pop_front();
        check("out", 64'(out), 64'(e_mon.out));
        check("res_out", 64'(res_out), 64'(e_mon.res));
        check("latency", 64'(pcyc), 64'(e_mon.due));
        check("busy_in_done", 64'(busy), 64'd1);
        // Reconstruction: sum of signed scales plus residual gives back act.
        bad = 0;
        for (int s = 0; s < S; s++) begin
          int sum;
          sum = int'($signed(res_out[s*RW +: RW]));
          for (int l = 0; l < L; l++) begin
            int gv;
            gv = int'({24'd0, e_mon.gam[l*A +: A]});
            sum = out[l*S+s] ? sum + gv : sum - gv;
          end
          if (sum != int'($signed(e_mon.act[s*A +: A]))) bad++;
        end
        check("roundtrip", 64'(bad), 64'd0);
        $display("run %0d act=%h gamma=%h out=%b res_out=%h", n_done, e_mon.act, e_mon.gam, out, res_out);
      end
    end
  end

  task automatic do_run(input logic [A*S-1:0] a, input logic [A*L-1:0] g, input bit hold_busy);
    exp_t e;
    int p0;
    @(posedge clk); #1;
    act   = a;
    gamma = g;
    start = 1'b1;
    p0    = pcyc;
    model(a, g, e.out, e.res);
    e.act = a;
    e.gam = g;
    e.due = p0 + 1 + L;
    sb.push_back(e);
    n_issued++;
    if (!hold_busy) begin
      @(posedge clk); #1;
      start = 1'b0;
      act   = $urandom;
      gamma = 16'($urandom);
    end else begin
      // Keep start high with shifting inputs through RUN and DONE.
      while (pcyc < p0 + L + 2) begin
        @(posedge clk); #1;
        act   = $urandom;
        gamma = 16'($urandom);
      end
      start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("idle_wait", 64'(k < 50), 64'd1);
  endtask

  localparam logic [A*S-1:0] BASIC_ACT = {8'd12, 8'd0, 8'hFD, 8'd10};
  localparam logic [A*L-1:0] BASIC_G   = {8'd4, 8'd8};
  localparam logic [RW*S-1:0] BASIC_RES = {11'd0, 11'h7FC, 11'd1, 11'h7FE};

  initial begin
    // 1. Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out", 64'(out), 64'd0);
    check("rst_res", 64'(res_out), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_quiet", 64'({done, busy}), 64'd0);
    end

    // 2. Basic
    do_run(BASIC_ACT, BASIC_G, 1'b0);
    wait_idle();
    check("basic_out", 64'(out), 64'hBD);
    check("basic_res", 64'(res_out), 64'(BASIC_RES));

    // 3. Start re-pulsed during RUN and DONE
    do_run(BASIC_ACT, BASIC_G, 1'b1);
    wait_idle();
    check("busy_out", 64'(out), 64'hBD);
    check("busy_res", 64'(res_out), 64'(BASIC_RES));
    check("busy_one_done", 64'(n_done), 64'(n_issued));

    // Reset clears held results
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_clr_out", 64'(out), 64'd0);
    check("rst_clr_res", 64'(res_out), 64'd0);

    // 4. Reset at the edge after start
    @(posedge clk); #1;
    act   = BASIC_ACT;
    gamma = BASIC_G;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rst   = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    @(negedge clk);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_out", 64'(out), 64'd0);
    check("mid_res", 64'(res_out), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mid_no_done", 64'(done), 64'd0);
    end
    do_run(BASIC_ACT, BASIC_G, 1'b0);
    wait_idle();
    check("mid_rerun_out", 64'(out), 64'hBD);
    check("mid_rerun_res", 64'(res_out), 64'(BASIC_RES));

    // 5. Extremes
    do_run({4{8'h80}}, {8'hFF, 8'hFF}, 1'b0);
    wait_idle();
    check("ext_out", 64'(out), 64'hF0);
    check("ext_res", 64'(res_out), 64'({4{11'h780}}));

    // 6. Random round-trip
    for (int i = 0; i < 1000; i++) begin
      do_run($urandom, 16'($urandom), ($urandom_range(0, 7) == 0));
      wait_idle();
    end

    check("all_done", 64'(n_done), 64'(n_issued));
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
